// File: rtl/nibble_adder_seq.sv
// Nibble-serial add/subtract sequencer driving one shared external 4-bit adder, LSB nibble first.
// Optional overflow/zero flags are enabled by defining NIBBLE_ADDER_SEQ_FLAGS_EN.
module nibble_adder_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 op_sub,
    input  logic [4*NIBBLES-1:0] a_in,
    input  logic [4*NIBBLES-1:0] b_in,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic                 carry_out,
    output logic                 overflow,
    output logic                 zero,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_cin,
    input  logic [3:0]           add_sum,
    input  logic                 add_cout
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_reg, state_next;
    logic [IW-1:0]   index_reg, index_next;
    logic [W-1:0]    a_reg, a_next;
    logic [W-1:0]    b_reg, b_next;
    logic [W-1:0]    result_reg, result_next;
    logic            carry_reg, carry_next;
    logic            carry_out_reg, carry_out_next;
    logic            accept;
    logic            last_nibble;

    assign accept      = start && (state_reg != RUN);
    assign last_nibble = (state_reg == RUN) && (index_reg == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            index_reg     <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            result_reg    <= '0;
            carry_reg     <= 1'b0;
            carry_out_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            index_reg     <= index_next;
            a_reg         <= a_next;
            b_reg         <= b_next;
            result_reg    <= result_next;
            carry_reg     <= carry_next;
            carry_out_reg <= carry_out_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        index_next     = index_reg;
        a_next         = a_reg;
        b_next         = b_reg;
        result_next    = result_reg;
        carry_next     = carry_reg;
        carry_out_next = carry_out_reg;
        add_a          = 4'h0;
        add_b          = 4'h0;
        add_cin        = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    // Subtraction is A + ~B + 1: invert B here and seed the carry.
                    state_next     = RUN;
                    index_next     = '0;
                    a_next         = a_in;
                    b_next         = op_sub ? ~b_in : b_in;
                    carry_next     = op_sub;
                    result_next    = '0;
                    carry_out_next = 1'b0;
                end else if (state_reg == DONE) begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                add_a   = a_reg[{index_reg, 2'b00} +: 4];
                add_b   = b_reg[{index_reg, 2'b00} +: 4];
                add_cin = carry_reg;
                result_next[{index_reg, 2'b00} +: 4] = add_sum;
                carry_next = add_cout;
                if (index_reg == LAST) begin
                    state_next     = DONE;
                    index_next     = '0;
                    carry_out_next = add_cout;
                end else begin
                    index_next = index_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy      = (state_reg == RUN);
    assign done      = (state_reg == DONE);
    assign result    = result_reg;
    assign carry_out = carry_out_reg;

`ifdef NIBBLE_ADDER_SEQ_FLAGS_EN
    logic overflow_reg;
    logic zero_reg;

    // Flags look at result_next so they see the nibble written on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_reg <= 1'b0;
            zero_reg     <= 1'b0;
        end else if (accept) begin
            overflow_reg <= 1'b0;
            zero_reg     <= 1'b0;
        end else if (last_nibble) begin
            overflow_reg <= (a_reg[W-1] == b_reg[W-1]) && (result_next[W-1] != a_reg[W-1]);
            zero_reg     <= (result_next == '0);
        end
    end

    assign overflow = overflow_reg;
    assign zero     = zero_reg;
`else
    logic unused_flag_inputs;
    assign unused_flag_inputs = accept ^ last_nibble;
    assign overflow = 1'b0;
    assign zero     = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_adder_seq.sv
// Directed self-checking bench for nibble_adder_seq (NIBBLES=4) with a behavioural shared adder.
module tb_nibble_adder_seq;
    localparam int NIBBLES = 4;
    localparam int W = 4 * NIBBLES;
`ifdef NIBBLE_ADDER_SEQ_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         op_sub = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         busy, done, carry_out, overflow, zero;
    logic [W-1:0] result;
    logic [3:0]   add_a, add_b, add_sum;
    logic         add_cin, add_cout;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // The shared external 4-bit adder.
    always_comb {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

    nibble_adder_seq #(.NIBBLES(NIBBLES)) dut (
        .clk(clk), .rst(rst), .start(start), .op_sub(op_sub),
        .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
        .result(result), .carry_out(carry_out), .overflow(overflow), .zero(zero),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one operation from a negedge; returns at the negedge where done is high.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          input logic [W-1:0] exp_r, input logic exp_c,
                          input logic exp_ov, input logic exp_z, input int poke);
        logic [W-1:0] bx;
        bx = sub ? ~b : b;
        start = 1'b1; a_in = a; b_in = b; op_sub = sub;
        @(negedge clk);
        start = 1'b0; a_in = '0; b_in = '0; op_sub = 1'b0;
        for (int k = 0; k < NIBBLES; k++) begin
            start = 1'b0;
            chk($sformatf("busy_c%0d", k), {31'b0, busy}, 32'd1);
            chk($sformatf("done_c%0d", k), {31'b0, done}, 32'd0);
            chk($sformatf("add_a_c%0d", k), {28'b0, add_a}, {28'b0, a[4*k +: 4]});
            chk($sformatf("add_b_c%0d", k), {28'b0, add_b}, {28'b0, bx[4*k +: 4]});
            if (k == 0) chk("add_cin_c0", {31'b0, add_cin}, {31'b0, sub});
            if (k == poke) begin
                start = 1'b1; a_in = 16'hAAAA; b_in = 16'h5555; op_sub = 1'b1;
            end
            @(negedge clk);
        end
        start = 1'b0; a_in = '0; b_in = '0; op_sub = 1'b0;
        chk("done_pulse", {31'b0, done}, 32'd1);
        chk("busy_done", {31'b0, busy}, 32'd0);
        chk("result", {16'b0, result}, {16'b0, exp_r});
        chk("carry_out", {31'b0, carry_out}, {31'b0, exp_c});
        chk("overflow", {31'b0, overflow}, {31'b0, FLAGS ? exp_ov : 1'b0});
        chk("zero", {31'b0, zero}, {31'b0, FLAGS ? exp_z : 1'b0});
        $display("op a=%h b=%h sub=%0d -> result=%h carry=%0d ovf=%0d zero=%0d",
                 a, b, sub, result, carry_out, overflow, zero);
    endtask

    initial begin
        int gap;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", {16'b0, result}, 32'd0);
        chk("rst_carry", {31'b0, carry_out}, 32'd0);
        chk("rst_flags", {30'b0, overflow, zero}, 32'd0);
        chk("rst_adder", {23'b0, add_a, add_b, add_cin}, 32'd0);

        // Add: nibbles 4/F, 3/F, 2/F, 1/0
        run_op(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, -1);
        @(negedge clk);
        chk("done_single", {31'b0, done}, 32'd0);
        chk("result_hold", {16'b0, result}, 32'h2233);
        chk("idle_adder", {23'b0, add_a, add_b, add_cin}, 32'd0);

        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, -1);
        run_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, -1);
        run_op(16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, -1);
        run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, -1);
        @(negedge clk);

        // start pulsed during RUN must be ignored
        run_op(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0, 1);
        @(negedge clk);

        // Abort with rst on the second RUN cycle
        start = 1'b1; a_in = 16'h1234; b_in = 16'h1111; op_sub = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("abort_busy_before", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_result", {16'b0, result}, 32'd0);
        chk("abort_adder", {23'b0, add_a, add_b, add_cin}, 32'd0);
        @(negedge clk);
        chk("abort_idle", {30'b0, busy, done}, 32'd0);
        $display("abort: busy=%0d done=%0d result=%h", busy, done, result);
        run_op(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, -1);

        // Back-to-back: start held during the DONE cycle
        start = 1'b1; a_in = 16'h0001; b_in = 16'h0001; op_sub = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", {31'b0, busy}, 32'd1);
        chk("b2b_cleared", {16'b0, result}, 32'd0);
        gap = 1;
        while (!done && gap < 12) begin
            @(negedge clk);
            gap++;
        end
        chk("b2b_gap", gap, 32'd5);
        chk("b2b_done", {31'b0, done}, 32'd1);
        chk("b2b_result", {16'b0, result}, 32'h0002);
        chk("b2b_carry", {31'b0, carry_out}, 32'd0);
        $display("b2b: gap=%0d result=%h", gap, result);
        @(negedge clk);
        chk("b2b_idle", {30'b0, busy, done}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
